// File: rtl/sobel_writeback_if.sv
// sobel_writeback_if
//   Handshake and write-port bundle between the Sobel result stream / FSM
//   and the sobel_writeback block.
//   Signals:
//     start     FSM level enable (sobel_en); the block runs while high
//     in_valid  Sobel result available
//     in_data   unsigned gradient magnitude, IW bits
//     in_ready  result accepted when in_valid & in_ready
//     wr_en     output-RAM write strobe
//     wr_addr   output-RAM write address (row*WIDTH+col), AW bits
//     wr_data   8-bit write data
//     done      frame complete (sobel_done)
//   Modports: master = FSM/result source side, slave = sobel_writeback.
interface sobel_writeback_if #(
  parameter int AW = 10,
  parameter int IW = 11
);
  logic          start;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, done
  );
endinterface

// File: rtl/sobel_writeback.sv
// sobel_writeback
//   Writes the Sobel magnitude frame back to the output RAM. Walks every
//   address of a WIDTH x HEIGHT frame once in raster order: border pixels
//   are written with zero without consuming input, interior pixels consume
//   one streamed magnitude each, saturated to 8 bits. done is raised once
//   the last address has been issued and held until start drops.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  sobel_writeback_if.slave (start, in_valid/in_data/in_ready,
//          wr_en/wr_addr/wr_data, done)
module sobel_writeback #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int AW     = 10,
  parameter int IW     = 11
) (
  input  logic               clk,
  input  logic               rst,
  sobel_writeback_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [AW-1:0] addr;
  logic          border;
  logic          at_last;
  logic          running;
  logic          advance;

  logic          vld_p1;
  logic [AW-1:0] addr_p1;
  logic [7:0]    data_p1;

  // Saturate the magnitude to the 8-bit pixel range.
  function automatic logic [7:0] clamp8(input logic [IW-1:0] x);
    return (x > IW'(255)) ? 8'hFF : x[7:0];
  endfunction

  assign border  = (row == '0) || (row == ROW_LAST) ||
                   (col == '0) || (col == COL_LAST);
  assign at_last = (addr == ADDR_LAST);
  // Dropping start in RUN aborts on that same edge, so nothing is
  // accepted or written once start is low.
  assign running = (state == RUN) && bus.start;
  assign advance = running && (border || bus.in_valid);

  assign bus.in_ready = running && !border;
  assign bus.done     = (state == DONE);
  assign bus.wr_en    = vld_p1;
  assign bus.wr_addr  = addr_p1;
  assign bus.wr_data  = data_p1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (!bus.start)              state_nxt = IDLE;
        else if (advance && at_last) state_nxt = DONE;
      end
      DONE: if (!bus.start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Cursor: row/col for border detection, addr kept as its own counter so
  // no row*WIDTH multiply is needed. Held at zero outside an active run.
  always_ff @(posedge clk) begin
    if (rst || !running || (advance && at_last)) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (advance) begin
      addr <= addr + 1'b1;
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // p0 -> p1: registered write strobe, one cycle after the advance edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= advance;
      if (advance) begin
        addr_p1 <= addr;
        data_p1 <= border ? 8'd0 : clamp8(bus.in_data);
      end
    end
  end

endmodule

// File: doc/sobel_writeback.md
# sobel_writeback

Result-side counterpart of the pixel address generator: where the address generator reads the 32x32 grayscale frame out of memory and raises its done flag, this block writes the Sobel magnitude frame back into the output RAM and raises `done` as the FSM's `sobel_done`. It walks every output address once in raster order. Border pixels get zero written without consuming input. Interior pixels consume one streamed result each, clamped to 8 bits.

## Interface
- `WIDTH`, default 32: image width in pixels (min 3).
- `HEIGHT`, default 32: image height in pixels (min 3).
- `AW`, default 10: address width; WIDTH*HEIGHT <= 2^AW.
- `IW`, default 11: input magnitude width.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: level enable from FSM (`sobel_en`); run while high.
- `in_valid`  in  1: Sobel result available.
- `in_data`  in  IW: unsigned gradient magnitude.
- `in_ready`  out  1: combinational; result accepted when `in_valid & in_ready`.
- `wr_en`  out  1: registered output-RAM write strobe.
- `wr_addr`  out  AW: registered write address, row*WIDTH+col.
- `wr_data`  out  8: registered write data.
- `done`  out  1: frame complete; drives FSM `sobel_done`.

## Operation
- States:
  - IDLE: cursor row=0, col=0.
  - RUN: walk addresses.
  - DONE: frame written.
- IDLE -> RUN when `start`=1 on a clock edge. Cursor is 0 on entry.
- RUN, cursor on a border pixel (row 0, row HEIGHT-1, col 0 or col WIDTH-1):
  - every cycle writes wr_addr=cursor, wr_data=0;
  - cursor advances; `in_ready`=0.
- RUN, cursor on an interior pixel:
  - `in_ready`=1;
  - on `in_valid`, writes wr_addr=cursor, wr_data=clamp(in_data) and advances;
  - on no `in_valid`, no write (wr_en=0) and the cursor holds.
- clamp(x) = x if x <= 255, else 255.
- Cursor advance: col+1; at col=WIDTH-1, col wraps to 0 and row increments. The address is a separately maintained counter, not a multiply.
- RUN -> DONE on the edge that issues the write for the last address (WIDTH*HEIGHT-1).
- DONE -> IDLE when `start`=0. `done` stays high until then.
- `start`=0 during RUN aborts to IDLE: cursor is cleared, no further writes are issued, and `done` is not raised.
- `in_ready` is 0 in IDLE and DONE. Input presented there is ignored and not consumed.
- `done` = (state==DONE). It is combinational from the state register.

## Timing
- All outputs are 0 during and after reset. State is IDLE, cursor 0.
- `rst` has priority over everything. Mid-frame reset drops the frame and the next `start` begins again at address 0.
- Cycle timing:
  - cycle 0: `start` sampled high;
  - cycle 1: RUN, cursor 0;
  - cycle 2: wr_en=1, wr_addr=0.
- Write latency is 1 cycle from the accept/advance edge to the registered strobe.
- Full-throughput frame (in_valid always 1): exactly WIDTH*HEIGHT consecutive wr_en cycles, i.e. 1024 at default parameters.
  - interior results consumed: (WIDTH-2)*(HEIGHT-2) = 900;
  - border zero writes: 124.
- `done` rises in the same cycle that wr_en/wr_addr for address WIDTH*HEIGHT-1 is presented.
- Each in_valid stall adds exactly one cycle with wr_en=0 and the address held.
- No write address is ever repeated or skipped within a frame.

## Test plan
- Reset then full frame:
  - stimulus: rst 3 cycles, start=1, in_valid=1, in_data=counter;
  - required: 1024 writes to addresses 0..1023 in order;
  - required: addr 33 gets data 0 (first consumed value), addr 34 gets 1, addr 990 gets 899&0xFF;
  - required: border addresses get 0; `done`=1 with the wr_addr=1023 cycle.
- Clamp:
  - stimulus: interior in_data = 255, 256, 2047;
  - required: written data 255, 255, 255. in_data=0 writes 0.
- Backpressure:
  - stimulus: in_valid low 5 cycles while the cursor is at addr 33;
  - required: wr_en=0 for those 5 cycles; addr 33 is written once, after in_valid rises;
  - required: border addresses 0..32 still stream with no gaps before the stall.
- Done handshake:
  - stimulus: keep start=1 for 10 cycles after done;
  - required: done held high, no writes, in_ready=0;
  - stimulus: start=0; required: done falls the next cycle and the state is IDLE.
  - stimulus: start=1 again; required: a new frame from address 0.
- Abort and reset mid-frame:
  - stimulus: start=0 at addr 500; required: writes stop, done never asserts;
  - stimulus: restart; required: writes from 0.
  - stimulus: rst at addr 700; required: all outputs 0 the next cycle.
- Parameter corner:
  - stimulus: WIDTH=HEIGHT=3, AW=4;
  - required: 9 writes, exactly one input consumed (at addr 4), done with addr 8.
